// File: rtl/trans_pkg.sv
// Shared transaction-layer constants.
// Lane FIFO geometry and lane count.
package trans_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 3;
  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_LANES  = 10;

endpackage

// File: rtl/fifo_mem.sv
// Lane FIFO storage array.
// One sync write port, one registered read port.
module fifo_mem
  import trans_pkg::*;
#(
  parameter int DW = trans_pkg::DATA_WIDTH,
  parameter int AW = trans_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [1<<AW];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; holds its value when idle.
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Per-lane FIFO with threshold flags.
// Sticky overflow/underflow, 1-cycle read latency.
module fifo_umbral
  import trans_pkg::*;
#(
  parameter int DATA_WIDTH = trans_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = trans_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_error,
  output logic                  underflow_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH =
    CW'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decisions from pre-edge occupancy.
  always_comb begin
    rd_ok = rd_enable && (count != '0);
    wr_ok = wr_enable && ((count < DEPTH) || rd_ok);
  end

  fifo_mem #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  // Pointers, occupancy and read-valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      valid_out <= rd_ok;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop indicators.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (wr_enable && !wr_ok) overflow_error  <= 1'b1;
      if (rd_enable && !rd_ok) underflow_error <= 1'b1;
    end
  end

  // Level flags decoded from registered count.
  always_comb begin
    fifo_empty   = (count == '0);
    fifo_full    = (count == DEPTH);
    almost_full  = (count >= {1'b0, umbral_alto});
    almost_empty = (count <= {1'b0, umbral_bajo});
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral.
// Vector table plus multi-cycle corner sequences.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable;
  logic [5:0] data_in;
  logic       rd_enable;
  logic [2:0] umbral_alto;
  logic [2:0] umbral_bajo;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow_error;
  logic       underflow_error;
  logic [3:0] count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_umbral dut (
    .clk             (clk),
    .reset           (reset),
    .wr_enable       (wr_enable),
    .data_in         (data_in),
    .rd_enable       (rd_enable),
    .umbral_alto     (umbral_alto),
    .umbral_bajo     (umbral_bajo),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .overflow_error  (overflow_error),
    .underflow_error (underflow_error),
    .count           (count)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [5:0] din;
    logic [3:0] cnt;
    logic [5:0] dout;
    logic       v;
    logic       emp;
    logic       ful;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input int row,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w,
                      input logic rd, input logic [5:0] d);
    @(negedge clk);
    reset     = ~r;
    wr_enable = w;
    rd_enable = rd;
    data_in   = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset     = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  task automatic chk_vec(input int i, input vec_t e);
    chk("count", i, 8'(count), 8'(e.cnt));
    chk("data_out", i, 8'(data_out), 8'(e.dout));
    chk("valid_out", i, 8'(valid_out), 8'(e.v));
    chk("fifo_empty", i, 8'(fifo_empty), 8'(e.emp));
    chk("fifo_full", i, 8'(fifo_full), 8'(e.ful));
    chk("almost_full", i, 8'(almost_full), 8'(e.af));
    chk("almost_empty", i, 8'(almost_empty), 8'(e.ae));
    chk("overflow", i, 8'(overflow_error), 8'(e.ovf));
    chk("underflow", i, 8'(underflow_error), 8'(e.unf));
  endtask

  // Drive one edge then check outputs 1 ns after it.
  task automatic apply(input int i, input vec_t e);
    @(negedge clk);
    reset     = ~e.rst;
    wr_enable = e.wr;
    rd_enable = e.rd;
    data_in   = e.din;
    @(posedge clk);
    #1;
    chk_vec(i, e);
  endtask

  initial begin
    //        rst wr rd din    cnt dout  v emp ful af ae ovf unf
    tbl[0]  = '{0,0,0,6'h00, 0,6'h00,0,1,0,0,1,0,0};
    tbl[1]  = '{0,1,0,6'h01, 1,6'h00,0,0,0,0,1,0,0};
    tbl[2]  = '{0,1,0,6'h02, 2,6'h00,0,0,0,0,1,0,0};
    tbl[3]  = '{0,1,0,6'h03, 3,6'h00,0,0,0,0,0,0,0};
    tbl[4]  = '{0,1,0,6'h04, 4,6'h00,0,0,0,0,0,0,0};
    tbl[5]  = '{0,1,0,6'h05, 5,6'h00,0,0,0,0,0,0,0};
    tbl[6]  = '{0,1,0,6'h06, 6,6'h00,0,0,0,1,0,0,0};
    tbl[7]  = '{0,1,0,6'h07, 7,6'h00,0,0,0,1,0,0,0};
    tbl[8]  = '{0,1,0,6'h08, 8,6'h00,0,0,1,1,0,0,0};
    tbl[9]  = '{0,1,0,6'h3F, 8,6'h00,0,0,1,1,0,1,0};
    tbl[10] = '{0,0,1,6'h00, 7,6'h01,1,0,0,1,0,1,0};
    tbl[11] = '{0,0,1,6'h00, 6,6'h02,1,0,0,1,0,1,0};
    tbl[12] = '{0,0,1,6'h00, 5,6'h03,1,0,0,0,0,1,0};
    tbl[13] = '{0,0,1,6'h00, 4,6'h04,1,0,0,0,0,1,0};
    tbl[14] = '{0,0,1,6'h00, 3,6'h05,1,0,0,0,0,1,0};
    tbl[15] = '{0,0,1,6'h00, 2,6'h06,1,0,0,0,1,1,0};
    tbl[16] = '{0,0,1,6'h00, 1,6'h07,1,0,0,0,1,1,0};
    tbl[17] = '{0,0,1,6'h00, 0,6'h08,1,1,0,0,1,1,0};
    tbl[18] = '{0,0,0,6'h00, 0,6'h08,0,1,0,0,1,1,0};
    tbl[19] = '{0,0,1,6'h00, 0,6'h08,0,1,0,0,1,1,1};
    tbl[20] = '{1,0,0,6'h00, 0,6'h00,0,1,0,0,1,0,0};

    reset       = 1'b0;
    wr_enable   = 1'b0;
    rd_enable   = 1'b0;
    data_in     = '0;
    umbral_alto = 3'd6;
    umbral_bajo = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) apply(i, tbl[i]);

    // Simultaneous read/write while full.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 6'(i));
    chk("fill_cnt", 100, 8'(count), 8'd8);
    step(0, 1, 1, 6'h2A);
    chk("rw_full_cnt", 101, 8'(count), 8'd8);
    chk("rw_full_ovf", 101, 8'(overflow_error), 8'd0);
    chk("rw_full_dout", 101, 8'(data_out), 8'h01);
    chk("rw_full_v", 101, 8'(valid_out), 8'd1);
    for (int i = 2; i <= 8; i++) begin
      step(0, 0, 1, 6'h00);
      chk("wrap_dout", 100 + i, 8'(data_out), 8'(i));
    end
    step(0, 0, 1, 6'h00);
    chk("wrap_last", 110, 8'(data_out), 8'h2A);
    chk("wrap_empty", 110, 8'(fifo_empty), 8'd1);

    // Read and write together on empty.
    step(0, 1, 1, 6'h15);
    chk("ec_unf", 120, 8'(underflow_error), 8'd1);
    chk("ec_v", 120, 8'(valid_out), 8'd0);
    chk("ec_cnt", 120, 8'(count), 8'd1);
    chk("ec_dout", 120, 8'(data_out), 8'h2A);
    umbral_bajo = 3'd0;
    umbral_alto = 3'd0;
    #1;
    chk("bajo0_ae", 121, 8'(almost_empty), 8'd0);
    chk("alto0_af", 121, 8'(almost_full), 8'd1);
    step(0, 0, 1, 6'h00);
    chk("ec_rd", 122, 8'(data_out), 8'h15);
    chk("ec_rd_v", 122, 8'(valid_out), 8'd1);
    chk("ec_empty", 122, 8'(fifo_empty), 8'd1);
    chk("alto0_af_e", 122, 8'(almost_full), 8'd1);
    chk("bajo0_ae_e", 122, 8'(almost_empty), 8'd1);
    umbral_alto = 3'd6;
    umbral_bajo = 3'd2;

    // Reset in the middle of operation.
    step(0, 0, 1, 6'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 6'(9 + i));
    step(0, 0, 1, 6'h00);
    step(0, 1, 0, 6'h0E);
    chk("mid_cnt", 130, 8'(count), 8'd5);
    step(1, 0, 0, 6'h00);
    chk("rst_cnt", 131, 8'(count), 8'd0);
    chk("rst_empty", 131, 8'(fifo_empty), 8'd1);
    chk("rst_ovf", 131, 8'(overflow_error), 8'd0);
    chk("rst_unf", 131, 8'(underflow_error), 8'd0);
    chk("rst_v", 131, 8'(valid_out), 8'd0);
    step(0, 1, 0, 6'h07);
    step(0, 0, 1, 6'h00);
    chk("post_dout", 132, 8'(data_out), 8'h07);
    chk("post_v", 132, 8'(valid_out), 8'd1);
    chk("post_empty", 132, 8'(fifo_empty), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
